// File: rtl/uart_rx_axis.sv
// Parametrised UART receiver: synchronised, majority-voted line sampling with
// parity/framing checks, feeding a small FIFO drained as an AXI-Stream master.
module uart_rx_axis #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic [1:0]           m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 overrun,
    output logic [7:0]           err_count,
    input  logic                 err_clr
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int BIT_W    = $clog2(DATA_BITS + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int WORD_W   = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    logic                 sync1_q, sync2_q;
    logic [2:0]           samp_q;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 push;
    logic                 stop_ferr;
    logic                 maj;
    logic                 tick;

    logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 empty, full, pop, do_push, drop;
    logic [WORD_W-1:0]    push_word, head_word;
    logic                 overrun_q;
    logic [7:0]           err_cnt_q;

    assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign tick      = (baud_cnt_q == CNT_LAST);
    assign stop_ferr = ferr_q | ~maj;
    assign push_word = {stop_ferr, perr_q, shreg_q};

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = tick ? '0 : baud_cnt_q + CNT_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!sync2_q) begin
                    baud_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_cnt_q == CNT_HALF) begin
                    if (maj) begin
                        state_d = S_IDLE;
                    end else begin
                        baud_cnt_d = '0;
                        bit_cnt_d  = '0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    perr_d  = ((^shreg_q) ^ maj) != (PARITY == 1);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    ferr_d = stop_ferr;
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        state_d = stop_ferr ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign do_push   = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign head_word = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: the FIFO storage has no reset; outputs are gated by tvalid so stale entries never leak out.
    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = m_axis_tvalid ? head_word[DATA_BITS-1:0] : '0;
    assign m_axis_tuser  = m_axis_tvalid ? head_word[WORD_W-1:DATA_BITS] : 2'b00;
    assign overrun       = overrun_q;
    assign err_count     = err_cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            samp_q     <= 3'b111;
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overrun_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            samp_q     <= {samp_q[1:0], sync2_q};
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;

            // A set/increment in the same cycle as err_clr takes priority over the clear.
            if (drop)         overrun_q <= 1'b1;
            else if (err_clr) overrun_q <= 1'b0;

            if (do_push && push_word[WORD_W-1:DATA_BITS] != 2'b00) begin
                if (err_clr)                err_cnt_q <= 8'd1;
                else if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else if (err_clr) begin
                err_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis: an 8N1 instance scored through a queue,
// plus an even-parity instance checked directly.
module tb_uart_rx_axis;

    localparam int BAUD_DIV = 16;

    logic       clk = 1'b0;
    logic       rst, rx, rx_p;
    logic       tready, tready_p, err_clr;
    logic [7:0] tdata, tdata_p;
    logic [1:0] tuser, tuser_p;
    logic       tvalid, tvalid_p, ovr, ovr_p;
    logic [7:0] errc, errc_p;

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    uart_rx_axis #(.CLK_FREQ(16_000_000), .BAUD(1_000_000)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .overrun(ovr), .err_count(errc), .err_clr(err_clr)
    );

    uart_rx_axis #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .PARITY(2)) dut_par (
        .clk(clk), .rst(rst), .rx(rx_p),
        .m_axis_tdata(tdata_p), .m_axis_tuser(tuser_p), .m_axis_tvalid(tvalid_p),
        .m_axis_tready(tready_p), .overrun(ovr_p), .err_count(errc_p), .err_clr(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input bit which, input logic v);
        if (which) rx_p = v;
        else       rx   = v;
    endtask

    // One bit period; optional one-clock low spike at the bit centre.
    task automatic drive_bit(input bit which, input logic b, input bit spike);
        @(negedge clk);
        set_line(which, b);
        if (spike) begin
            repeat (8) @(negedge clk);
            set_line(which, 1'b0);
            @(negedge clk);
            set_line(which, b);
            repeat (6) @(negedge clk);
        end else begin
            repeat (BAUD_DIV - 1) @(negedge clk);
        end
    endtask

    task automatic send_frame(input bit which, input logic [7:0] data, input bit par_en,
                              input logic par_bit, input int spike);
        drive_bit(which, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i], spike == i);
        if (par_en) drive_bit(which, par_bit, 1'b0);
        drive_bit(which, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: a transfer happens on the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (!rst && tvalid && tready) begin
            if (sb.size() == 0) begin
                check("spurious_word", tvalid, 1'b0);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                check("tdata", tdata, e[7:0]);
                check("tuser", tuser, e[9:8]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx = 1'b1; rx_p = 1'b1;
        tready = 1'b1; tready_p = 1'b0; err_clr = 1'b0;
        idle(5);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tdata", tdata, 8'h00);
        check("rst_overrun", ovr, 1'b0);
        check("rst_errc", errc, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(10);

        // 8N1 basic with latency window around the stop-bit centre
        tready = 1'b0;
        sb.push_back({2'b00, 8'hA5});
        fork
            send_frame(1'b0, 8'hA5, 1'b0, 1'b0, -1);
            begin
                repeat (153) @(negedge clk);
                #1 check("lat_before_stop_centre", tvalid, 1'b0);
                repeat (8) @(negedge clk);
                #1 check("lat_after_stop_centre", tvalid, 1'b1);
            end
        join
        @(negedge clk);
        tready = 1'b1;
        idle(20);

        // Glitch rejection
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        idle(60);
        sb.push_back({2'b00, 8'hFF});
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 3);
        idle(20);

        // Break: one framing-error word, then recovery on a new frame
        sb.push_back({2'b10, 8'h00});
        @(negedge clk);
        rx = 1'b0;
        repeat (40 * BAUD_DIV) @(negedge clk);
        rx = 1'b1;
        idle(40);
        check("break_errc", errc, 8'd1);
        sb.push_back({2'b00, 8'h5A});
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, -1);
        idle(20);

        // Even parity instance
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, -1);
        for (int i = 0; i < 400 && !tvalid_p; i++) idle(1);
        check("par_valid1", tvalid_p, 1'b1);
        check("par_tdata1", tdata_p, 8'h03);
        check("par_tuser1", tuser_p, 2'b01);
        check("par_errc1", errc_p, 8'd1);
        @(negedge clk); tready_p = 1'b1;
        @(negedge clk); tready_p = 1'b0;
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, -1);
        for (int i = 0; i < 400 && !tvalid_p; i++) idle(1);
        check("par_valid2", tvalid_p, 1'b1);
        check("par_tuser2", tuser_p, 2'b00);
        check("par_errc2", errc_p, 8'd1);
        @(negedge clk); tready_p = 1'b1;
        idle(5);

        // Backpressure and overrun
        tready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back({2'b00, 8'(i)});
            send_frame(1'b0, 8'(i), 1'b0, 1'b0, -1);
        end
        idle(20);
        check("overrun_set", ovr, 1'b1);
        check("full_tvalid", tvalid, 1'b1);
        @(negedge clk);
        tready = 1'b1;
        idle(10);
        check("drained_tvalid", tvalid, 1'b0);
        check("overrun_held", ovr, 1'b1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        #1;
        check("clr_overrun", ovr, 1'b0);
        check("clr_errc", errc, 8'd0);

        // Reset mid-frame, with a stale word parked in the FIFO
        tready = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, -1);
        idle(5);
        check("parked_tvalid", tvalid, 1'b1);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; rx = 1'b1;
        idle(1);
        check("midrst_tvalid", tvalid, 1'b0);
        check("midrst_tdata", tdata, 8'h00);
        check("midrst_tuser", tuser, 2'b00);
        check("midrst_overrun", ovr, 1'b0);
        check("midrst_errc", errc, 8'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tready = 1'b1;
        idle(20);
        sb.push_back({2'b00, 8'h3C});
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, -1);
        idle(50);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
